// File: rtl/scan_index_sequencer_pkg.sv
// Shared encodings and the index-advance rule for the scan index sequencer.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package scan_index_sequencer_pkg;

  // Scan modes, sampled from the mode port at start
  localparam logic [1:0] MODE_UP    = 2'b00;
  localparam logic [1:0] MODE_DN    = 2'b01;
  localparam logic [1:0] MODE_PP    = 2'b10;
  localparam logic [1:0] MODE_SWEEP = 2'b11;

  // Sequencer FSM states
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  // Ping-pong direction
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Result of one dwell expiry: next index/direction, whether the step is the
  // cycle boundary, and whether a single sweep has just finished (no step then).
  typedef struct packed {
    logic [2:0] x;
    logic       dir;
    logic       wrap;
    logic       last;
  } adv_t;

  function automatic adv_t next_index(input logic [1:0] m,
                                      input logic [2:0] cur,
                                      input logic       dir);
    adv_t a;
    a.x    = cur;
    a.dir  = dir;
    a.wrap = 1'b0;
    a.last = 1'b0;
    case (m)
      MODE_UP: begin
        a.x    = cur + 3'd1;
        a.wrap = (cur == 3'd7);
      end
      MODE_DN: begin
        a.x    = cur - 3'd1;
        a.wrap = (cur == 3'd0);
      end
      MODE_PP: begin
        // Direction flips on arrival at either end, so 7 and 0 are each
        // visited once per period.
        if (dir == DIR_UP) begin
          a.x = cur + 3'd1;
          if (cur == 3'd6) a.dir = DIR_DN;
        end else begin
          a.x = cur - 3'd1;
          if (cur == 3'd1) begin
            a.dir  = DIR_UP;
            a.wrap = 1'b1;
          end
        end
      end
      default: begin
        // Single sweep: the dwell of 7 ends the sweep instead of stepping.
        if (cur == 3'd7) a.last = 1'b1;
        else             a.x    = cur + 3'd1;
      end
    endcase
    return a;
  endfunction

endpackage

// File: rtl/scan_index_sequencer_dwell_prescaler.sv
// Dwell prescaler: counts cycles spent on the current index and flags expiry.
// Latency: tick is combinational from the count; count updates on the next edge.
// Backpressure: run=0 freezes the count; clr wins over run.
module scan_index_sequencer_dwell_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;

  // ">=" lets a div lowered below the running count expire on the next cycle
  assign tick = run && (cnt >= div);

  // Dwell counter: cleared on restart/disable, held while not running
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/scan_index_sequencer.sv
// Timed 3-bit scan index for a downstream 3-to-8 decoder, four scan modes.
// Latency: start at edge N -> busy and start index after N; first step div+1 cycles later.
// Backpressure: hold pauses index and dwell count; en=0 forces idle.
module scan_index_sequencer
  import scan_index_sequencer_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             hold,
  output logic [2:0]       x,
  output logic             busy,
  output logic             step,
  output logic             wrap,
  output logic             done
);

  logic [1:0] state;
  logic [1:0] mode_q;
  logic       dir;
  logic       tick;
  logic       cnt_clr;
  logic       cnt_run;
  adv_t       adv;

  // Restart and disable both begin a fresh dwell; only RUN counts
  assign cnt_clr = !en || start;
  assign cnt_run = (state == S_RUN);

  scan_index_sequencer_dwell_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .run     (cnt_run),
    .div     (div),
    .tick    (tick)
  );

  assign adv  = next_index(mode_q, x, dir);
  assign busy = (state != S_IDLE);

  // FSM, index/direction registers and single-cycle status pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      x      <= 3'd0;
      dir    <= DIR_UP;
      mode_q <= MODE_UP;
      step   <= 1'b0;
      wrap   <= 1'b0;
      done   <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      done <= 1'b0;
      if (!en) begin
        state <= S_IDLE;
      end else if (start) begin
        // Restart from any state; a coincident tick is discarded
        state  <= S_RUN;
        mode_q <= mode;
        x      <= (mode == MODE_DN) ? 3'd7 : 3'd0;
        dir    <= DIR_UP;
      end else begin
        case (state)
          S_RUN: begin
            if (tick && adv.last) begin
              // Sweep finished: x stays on 7, hold is irrelevant now
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              // A tick coincident with hold still completes before pausing
              if (tick) begin
                x    <= adv.x;
                dir  <= adv.dir;
                step <= 1'b1;
                wrap <= adv.wrap;
              end
              if (hold) state <= S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (!hold) state <= S_RUN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_index_sequencer.sv
// Bench for scan_index_sequencer: x feeds a 3-to-8 decoder, outputs scoreboarded per cycle.
// Latency: expectations are queued at each edge and popped on the following falling edge.
// Backpressure: none; the design presents outputs every cycle.
module tb_scan_index_sequencer;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic             start;
  logic             hold;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic [2:0]       x;
  logic             busy;
  logic             step;
  logic             wrap;
  logic             done;
  logic [7:0]       y;

  always #5 clk = ~clk;

  scan_index_sequencer #(.DIV_W(DIV_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .start   (start),
    .mode    (mode),
    .div     (div),
    .hold    (hold),
    .x       (x),
    .busy    (busy),
    .step    (step),
    .wrap    (wrap),
    .done    (done)
  );

  // Downstream 3-to-8 decoder
  always_comb begin
    y    = 8'h00;
    y[x] = 1'b1;
  end

  typedef struct packed {
    logic [2:0] x;
    logic       busy;
    logic       step;
    logic       wrap;
    logic       done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  // Reference model: position within the mode's index sequence plus elapsed dwell
  bit m_active = 0;
  bit m_paused = 0;
  int m_mode   = 0;
  int m_pos    = 0;
  int m_x      = 0;
  int m_elapsed = 0;

  function automatic int seq_val(input int md, input int pos);
    case (md)
      0:       return pos % 8;
      1:       return 7 - (pos % 8);
      2:       return ((pos % 14) < 8) ? (pos % 14) : (14 - (pos % 14));
      default: return pos;
    endcase
  endfunction

  function automatic int period(input int md);
    return (md == 2) ? 14 : 8;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc_n, got, expv);
    end
  endtask

  function automatic void model_edge();
    exp_t e;
    bit   st = 0;
    bit   wr = 0;
    bit   dn = 0;
    if (!reset_n) begin
      m_active = 0; m_paused = 0; m_x = 0; m_elapsed = 0;
    end else if (!en) begin
      m_active = 0; m_paused = 0; m_elapsed = 0;
    end else if (start) begin
      m_active = 1; m_paused = 0; m_mode = int'(mode); m_pos = 0;
      m_x = seq_val(m_mode, 0); m_elapsed = 0;
    end else if (m_active && !m_paused) begin
      if (m_elapsed >= int'(div)) begin
        m_elapsed = 0;
        if (m_mode == 3 && m_pos == 7) begin
          dn = 1;
          m_active = 0;
        end else begin
          m_pos = (m_mode == 3) ? m_pos + 1 : (m_pos + 1) % period(m_mode);
          st = 1;
          wr = (m_mode != 3) && (m_pos == 0);
          m_x = seq_val(m_mode, m_pos);
        end
      end else begin
        m_elapsed++;
      end
      if (m_active && hold) m_paused = 1;
    end else if (m_active && m_paused && !hold) begin
      m_paused = 0;
    end
    e.x = 3'(m_x); e.busy = m_active; e.step = st; e.wrap = wr; e.done = dn;
    sb.push_back(e);
  endfunction

  // Drive one cycle of inputs, then record the expected post-edge outputs
  task automatic cyc(input int r, input int e, input int s, input int h,
                     input int md, input int dv);
    @(negedge clk);
    reset_n = (r != 0);
    en      = (e != 0);
    start   = (s != 0);
    hold    = (h != 0);
    mode    = 2'(md);
    div     = DIV_W'(dv);
    @(posedge clk);
    model_edge();
  endtask

  // Monitor: compare outputs and decoder against the oldest expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("x",    {5'd0, x},    {5'd0, mon_e.x});
      check("busy", {7'd0, busy}, {7'd0, mon_e.busy});
      check("step", {7'd0, step}, {7'd0, mon_e.step});
      check("wrap", {7'd0, wrap}, {7'd0, mon_e.wrap});
      check("done", {7'd0, done}, {7'd0, mon_e.done});
      check("y",    y,            8'h01 << mon_e.x);
    end
    cyc_n++;
  end

  initial begin
    int first_wrap;
    int k;
    reset_n = 1'b0; en = 1'b0; start = 1'b0; hold = 1'b0; mode = 2'd0; div = '0;

    // Reset with random other inputs
    repeat (2) cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 7));

    // Up-continuous, div=2: wrap 24 cycles after start
    cyc(1, 1, 1, 0, 0, 2);
    first_wrap = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc(1, 1, 0, 0, 0, 2);
      #1;
      if (wrap && first_wrap == 0) first_wrap = i;
    end
    check("wrap_latency", 8'(first_wrap), 8'd24);

    // Single sweep, div=0
    cyc(1, 1, 1, 0, 3, 0);
    repeat (12) cyc(1, 1, 0, 0, 3, 0);

    // Ping-pong, div=0
    cyc(1, 1, 1, 0, 2, 0);
    repeat (20) cyc(1, 1, 0, 0, 2, 0);

    // Hold mid-dwell, disable, then restart from x=5
    cyc(1, 1, 1, 0, 0, 3);
    repeat (5)  cyc(1, 1, 0, 0, 0, 3);
    repeat (5)  cyc(1, 1, 0, 1, 0, 3);
    repeat (10) cyc(1, 1, 0, 0, 0, 3);
    repeat (2)  cyc(1, 0, 0, 0, 0, 3);
    cyc(1, 1, 1, 0, 0, 3);
    k = 0;
    while (m_x != 5 && k < 100) begin
      cyc(1, 1, 0, 0, 0, 3);
      k++;
    end
    #1;
    check("reach_x5", {5'd0, x}, 8'd5);
    cyc(1, 1, 1, 0, 0, 3);
    repeat (3) cyc(1, 1, 0, 0, 0, 3);

    // Reset mid-run at x=4, then lower div mid-dwell
    cyc(1, 1, 1, 0, 0, 1);
    k = 0;
    while (m_x != 4 && k < 100) begin
      cyc(1, 1, 0, 0, 0, 1);
      k++;
    end
    #1;
    check("reach_x4", {5'd0, x}, 8'd4);
    cyc(0, 1, 0, 0, 0, 1);
    repeat (2) cyc(1, 1, 0, 0, 0, 9);
    cyc(1, 1, 1, 0, 0, 9);
    repeat (5) cyc(1, 1, 0, 0, 0, 9);
    cyc(1, 1, 0, 0, 0, 1);
    repeat (4) cyc(1, 1, 0, 0, 0, 1);

    // Randomized traffic
    repeat (2000) begin
      cyc(($urandom_range(0, 199) != 0) ? 1 : 0,
          ($urandom_range(0, 15) != 0) ? 1 : 0,
          ($urandom_range(0, 19) == 0) ? 1 : 0,
          ($urandom_range(0, 7) == 0) ? 1 : 0,
          $urandom_range(0, 3),
          ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 4));
    end

    @(negedge clk);
    #1;
    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
